// File: rtl/tx_pkt_scheduler_pkg.sv
// Shared definitions for the TX packet scheduler: default sizing, FSM state
// encoding and the modular-wrap helper used by the round-robin search.
package tx_pkt_scheduler_pkg;

   localparam int DEF_NUM_CHAN  = 2;
   localparam int DEF_IDX_W     = 2;
   localparam int DEF_CMD_BURST = 4;
   localparam int DEF_WDOG_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_HOLD    = 2'd2,
      ST_RELEASE = 2'd3
   } sched_state_t;

   // base and ofs are both below modulus, so one subtraction wraps the sum
   function automatic int wrap_add(input int base, input int ofs, input int modulus);
      int sum;
      sum = base + ofs;
      if (sum >= modulus) begin
         return sum - modulus;
      end else begin
         return sum;
      end
   endfunction

endpackage

// File: rtl/tx_pkt_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first active request at or above the
// pointer, wrapping past the top, reported as one-hot plus binary index.
module tx_pkt_scheduler_rr_arbiter
   import tx_pkt_scheduler_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_CHAN,
   parameter int IDX_W   = DEF_IDX_W
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   // Outer loop walks the search order, inner loop maps it onto a channel
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!o_any && i_req[j] && (wrap_add(int'(i_ptr), k, NUM_REQ) == j)) begin
               o_gnt[j] = 1'b1;
               o_idx    = IDX_W'(j);
               o_any    = 1'b1;
            end else begin
               o_any = o_any;
            end
         end
      end
   end

endmodule

// File: rtl/tx_pkt_scheduler.sv
// Grants the shared TX readout path one whole packet at a time: command
// channel first within a burst cap, data channels round-robin, with a watchdog.
module tx_pkt_scheduler
   import tx_pkt_scheduler_pkg::*;
#(
   parameter int NUM_CHAN  = DEF_NUM_CHAN,
   parameter int IDX_W     = DEF_IDX_W,
   parameter int CMD_BURST = DEF_CMD_BURST,
   parameter int WDOG_W    = DEF_WDOG_W
) (
   input  logic                txclk,
   input  logic                reset_n,
   input  logic [NUM_CHAN:0]   pkt_waiting,
   input  logic [NUM_CHAN:0]   rd_done,
   input  logic [NUM_CHAN:0]   chan_enable,
   input  logic [WDOG_W-1:0]   max_hold,
   output logic [NUM_CHAN:0]   grant,
   output logic [IDX_W-1:0]    grant_idx,
   output logic                start,
   output logic                busy,
   output logic                timeout
);

   localparam int               RUN_W     = $clog2(CMD_BURST + 1);
   localparam logic [IDX_W-1:0] CMD_IDX   = IDX_W'(NUM_CHAN);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(NUM_CHAN - 1);
   localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(CMD_BURST);

   sched_state_t        r_state;
   logic [IDX_W-1:0]    r_rr_ptr;
   logic [IDX_W-1:0]    r_win_idx;
   logic                r_win_cmd;
   logic [RUN_W-1:0]    r_cmd_run;
   logic [WDOG_W-1:0]   r_wdog;

   logic [NUM_CHAN:0]   w_elig;
   logic [NUM_CHAN:0]   w_win_gnt;
   logic [NUM_CHAN-1:0] w_rr_gnt;
   logic [IDX_W-1:0]    w_rr_idx;
   logic [IDX_W-1:0]    w_win_idx;
   logic                w_rr_any;
   logic                w_cmd_win;
   logic                w_done;
   logic                w_expire;

   assign w_elig = pkt_waiting & chan_enable;

   tx_pkt_scheduler_rr_arbiter #(
      .NUM_REQ (NUM_CHAN),
      .IDX_W   (IDX_W)
   ) u_rr_arb (
      .i_req (w_elig[NUM_CHAN-1:0]),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_rr_gnt),
      .o_idx (w_rr_idx),
      .o_any (w_rr_any)
   );

   // Command wins unless it has used its burst while data is also eligible
   always_comb begin
      w_cmd_win = w_elig[NUM_CHAN] && ((r_cmd_run < RUN_MAX) || !w_rr_any);
      if (w_cmd_win) begin
         w_win_gnt = {1'b1, {NUM_CHAN{1'b0}}};
         w_win_idx = CMD_IDX;
      end else begin
         w_win_gnt = {1'b0, w_rr_gnt};
         w_win_idx = w_rr_idx;
      end
   end

   // Only the granted channel's completion counts; it outranks expiry below
   assign w_done   = |(rd_done & grant);
   assign w_expire = (max_hold != '0) && (r_wdog == (max_hold - WDOG_W'(1)));

   // Scheduler FSM with registered grant, status and pulse outputs
   always_ff @(posedge txclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_rr_ptr  <= '0;
         r_win_idx <= '0;
         r_win_cmd <= 1'b0;
         r_cmd_run <= '0;
         r_wdog    <= '0;
         grant     <= '0;
         grant_idx <= '0;
         start     <= 1'b0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         start   <= 1'b0;
         timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_elig != '0) begin
                  r_state   <= ST_GRANT;
                  r_win_idx <= w_win_idx;
                  r_win_cmd <= w_cmd_win;
                  r_wdog    <= '0;
                  grant     <= w_win_gnt;
                  grant_idx <= w_win_idx;
                  start     <= 1'b1;
                  busy      <= 1'b1;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_GRANT, ST_HOLD: begin
               if (r_wdog != '1) begin
                  r_wdog <= r_wdog + WDOG_W'(1);
               end else begin
                  r_wdog <= r_wdog;
               end
               if (w_done) begin
                  r_state   <= ST_RELEASE;
                  grant     <= '0;
                  grant_idx <= '0;
               end else if (w_expire) begin
                  r_state   <= ST_RELEASE;
                  grant     <= '0;
                  grant_idx <= '0;
                  timeout   <= 1'b1;
               end else begin
                  r_state <= ST_HOLD;
               end
            end
            ST_RELEASE: begin
               r_state <= ST_IDLE;
               busy    <= 1'b0;
               if (r_win_cmd) begin
                  if (r_cmd_run != RUN_MAX) begin
                     r_cmd_run <= r_cmd_run + RUN_W'(1);
                  end else begin
                     r_cmd_run <= r_cmd_run;
                  end
               end else begin
                  r_cmd_run <= '0;
                  r_rr_ptr  <= (r_win_idx == LAST_DATA) ? '0 : r_win_idx + IDX_W'(1);
               end
            end
            default: begin
               r_state   <= ST_IDLE;
               grant     <= '0;
               grant_idx <= '0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
